// File: rtl/minall_seq.sv
// rtl/minall_seq.sv - sequential MINALL sweep: minimum of a register file, written back to dest
//
// Walks registers 0..NUM_REGS-1 through an external combinational read port,
// folds them through an external ALU in MINALL mode (unsigned minimum), then
// writes the minimum to the destination register captured at start.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   start, dest   sweep request (sampled only in IDLE) and destination address
//   busy, done    high during LOAD/SCAN/WRITE; one-cycle pulse in WRITE
//   rf_raddr      register file read address; rf_rdata is its same-cycle data
//   alu_ins       ALU opcode, 4'b0111 while busy, else 4'b0000
//   alu_a, alu_b  ALU operands; alu_out is the combinational ALU result
//   rf_we, rf_waddr, rf_wdata  register file write port, active in WRITE
//   result        last completed minimum, held until the next WRITE
module minall_seq #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] dest,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [3:0]        alu_ins,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] result
);

  localparam logic [3:0]        OP_MINALL = 4'b0111;
  localparam logic [3:0]        OP_NONE   = 4'b0000;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, WRITE} state_t;

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] dest_q;

  // The read port and ALU operands must be combinational: rf_rdata answers
  // rf_raddr in the same cycle and feeds alu_b directly.
  always_comb begin
    rf_raddr = '0;
    alu_a    = '0;
    alu_b    = '0;
    if (state == SCAN) begin
      rf_raddr = idx;
      alu_a    = acc;
      alu_b    = rf_rdata;
    end
  end

  // Control outputs are registered: each is set on the edge that enters the
  // state in which it must be valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      idx      <= '0;
      dest_q   <= '0;
      result   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      alu_ins  <= OP_NONE;
    end else begin
      done  <= 1'b0;
      rf_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dest_q  <= dest;
            busy    <= 1'b1;
            alu_ins <= OP_MINALL;
            state   <= LOAD;
          end
        end
        LOAD: begin
          // rf_raddr is 0 here, so rf_rdata is register 0
          acc   <= rf_rdata;
          idx   <= ADDR_W'(1);
          state <= SCAN;
        end
        SCAN: begin
          acc <= alu_out;
          if (idx == LAST_IDX) begin
            // alu_out is the final minimum; it becomes acc on this same edge
            done     <= 1'b1;
            rf_we    <= 1'b1;
            rf_waddr <= dest_q;
            rf_wdata <= alu_out;
            state    <= WRITE;
          end else begin
            idx <= idx + ADDR_W'(1);
          end
        end
        WRITE: begin
          result   <= acc;
          busy     <= 1'b0;
          alu_ins  <= OP_NONE;
          rf_waddr <= '0;
          rf_wdata <= '0;
          state    <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          alu_ins <= OP_NONE;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_minall_seq.sv
// tb/tb_minall_seq.sv - randomized self-checking bench for minall_seq
module tb_minall_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  dest;
  logic        busy;
  logic        done;
  logic [2:0]  rf_raddr;
  logic [15:0] rf_rdata;
  logic [3:0]  alu_ins;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_out;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [15:0] result;

  logic [15:0] regs [8];
  int checks;
  int errors;
  int we_total;

  minall_seq #(.DATA_W(16), .NUM_REGS(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .dest(dest),
    .busy(busy), .done(done),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .alu_ins(alu_ins), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rf_rdata = regs[rf_raddr];
  assign alu_out  = (alu_a < alu_b) ? alu_a : alu_b;

  always @(negedge clk) if (rf_we) we_total++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_min();
    logic [15:0] m;
    m = 16'hFFFF;
    for (int i = 0; i < 8; i++) if (regs[i] < m) m = regs[i];
    return m;
  endfunction

  // One sweep from IDLE; mask[k] is the start level driven during cycle k
  // (cycle 1 = LOAD, cycle 9 = WRITE). dest is scrambled after acceptance.
  task automatic sweep(input logic [2:0] d, input logic [15:0] expv, input logic [16:0] mask);
    int dk, nb, nw;
    logic [2:0]  wa;
    logic [15:0] wd;
    dk = 0; nb = 0; nw = 0; wa = 0; wd = 0;
    start = 1'b1;
    dest  = d;
    @(negedge clk);
    dest = ~d;
    for (int k = 1; k <= 16; k++) begin
      if (!busy) break;
      nb++;
      chk("alu_ins_busy", alu_ins, 4'b0111);
      if (done) dk = k;
      if (rf_we) begin
        nw++;
        wa = rf_waddr;
        wd = rf_wdata;
      end
      start = mask[k];
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_cycles", nb, 9);
    chk("done_cycle", dk, 9);
    chk("we_count", nw, 1);
    chk("waddr", wa, d);
    chk("wdata", wd, expv);
    chk("result", result, expv);
    chk("alu_ins_idle", alu_ins, 4'b0000);
  endtask

  initial begin
    int wb, nd, d1, d2;
    logic [15:0] e;
    checks = 0; errors = 0; we_total = 0;
    rst = 1'b1; start = 1'b0; dest = 3'd0;
    for (int i = 0; i < 8; i++) regs[i] = 16'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_result", result, 0);
    chk("rst_alu_ins", alu_ins, 0);
    chk("rst_raddr", rf_raddr, 0);
    chk("rst_alu_a", alu_a, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed example sweep
    regs[0] = 9; regs[1] = 4; regs[2] = 7; regs[3] = 12;
    regs[4] = 3; regs[5] = 15; regs[6] = 8; regs[7] = 6;
    sweep(3'd5, 16'd3, 17'd0);

    // Boundary values
    for (int i = 0; i < 8; i++) regs[i] = 16'hFFFF;
    sweep(3'd0, 16'hFFFF, 17'd0);
    for (int i = 0; i < 8; i++) regs[i] = 16'h8000;
    regs[7] = 16'h0001;
    sweep(3'd7, 16'h0001, 17'd0);
    for (int i = 0; i < 8; i++) regs[i] = 16'h8000;
    regs[0] = 16'h0000;
    sweep(3'd2, 16'h0000, 17'd0);

    // start pulsed in LOAD (1), mid-SCAN (4) and WRITE (9): all ignored
    for (int i = 0; i < 8; i++) regs[i] = 16'($urandom_range(0, 65535));
    wb = we_total;
    sweep(3'd6, ref_min(), 17'b0_0000_0010_0001_0010);
    repeat (3) @(negedge clk);
    chk("pulse_idle_busy", busy, 0);
    chk("pulse_we_total", we_total - wb, 1);

    // Abort in the 4th SCAN cycle (cycle 5)
    wb = we_total;
    start = 1'b1; dest = 3'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_we", rf_we, 0);
    chk("abort_result", result, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_no_write", we_total - wb, 0);
    chk("abort_idle", busy, 0);
    for (int i = 0; i < 8; i++) regs[i] = 16'($urandom_range(0, 65535));
    sweep(3'd4, ref_min(), 17'd0);

    // start held high for 20 cycles: back-to-back sweeps
    for (int i = 0; i < 8; i++) regs[i] = 16'($urandom_range(100, 200));
    e = ref_min();
    wb = we_total; nd = 0; d1 = 0; d2 = 0;
    start = 1'b1; dest = 3'd3;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (nd == 1) d1 = k; else d2 = k;
      end
      if (k >= 20) start = 1'b0;
    end
    chk("held_done_count", nd, 2);
    chk("held_done_first", d1, 9);
    chk("held_done_second", d2, 19);
    chk("held_we_total", we_total - wb, 2);
    chk("held_result", result, e);
    chk("held_idle", busy, 0);

    // Randomized sweeps with random data, dest and ignored start pulses
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 8; i++) begin
        if (n % 3 == 0) regs[i] = 16'($urandom_range(16'hFFF0, 16'hFFFF));
        else regs[i] = 16'($urandom_range(0, 65535));
      end
      sweep(3'($urandom_range(0, 7)), ref_min(), 17'($urandom) & 17'h003FE);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/minall_seq.md
MINALL_SEQ -- requirements
Module: minall_seq

Interface
REQ-001 Parameter DATA_W, default 16, datapath width in bits.
REQ-002 Parameter NUM_REGS, default 8, registers swept per operation; legal range 2..2**ADDR_W.
REQ-003 Parameter ADDR_W, default 3, register address width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 start  in  1  request to begin a MINALL sweep; sampled only in IDLE.
REQ-007 dest  in  ADDR_W  destination register; captured on the accepted start.
REQ-008 busy  out  1  high while in LOAD, SCAN or WRITE.
REQ-009 done  out  1  one-cycle pulse in WRITE.
REQ-010 rf_raddr  out  ADDR_W  register file read address.
REQ-011 rf_rdata  in  DATA_W  register file read data, combinational from rf_raddr in the same cycle.
REQ-012 alu_ins  out  4  ALU opcode: 4'b0111 (MINALL) while busy, else 4'b0000.
REQ-013 alu_a, alu_b  out  DATA_W each  ALU operands.
REQ-014 alu_out  in  DATA_W  ALU result, combinational; unsigned minimum of alu_a and alu_b.
REQ-015 rf_we  out  1  register file write enable.
REQ-016 rf_waddr  out  ADDR_W  register file write address.
REQ-017 rf_wdata  out  DATA_W  register file write data.
REQ-018 result  out  DATA_W  last completed minimum, held until the next WRITE.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, SCAN and WRITE; internal registers SHALL be acc (DATA_W), idx (ADDR_W) and dest_q (ADDR_W).
REQ-020 IDLE: start=1 -> dest_q<=dest, go to LOAD; start=0 -> stay in IDLE.
REQ-021 LOAD: rf_raddr=0, acc<=rf_rdata, idx<=1, go to SCAN.
REQ-022 SCAN: rf_raddr=idx, alu_a=acc, alu_b=rf_rdata, acc<=alu_out.
REQ-023 SCAN exit: idx==NUM_REGS-1 -> go to WRITE; otherwise idx<=idx+1 and stay in SCAN.
REQ-024 WRITE: rf_we=1, rf_waddr=dest_q, rf_wdata=acc, done=1, result<=acc, go to IDLE.
REQ-025 Latency: start sampled at edge E0 -> done high between E(NUM_REGS) and E(NUM_REGS+1); for default parameters, 9 cycles from E0 to the end of done, with done in cycle 9.
REQ-026 busy SHALL rise after E0 and fall after E(NUM_REGS+1).
REQ-027 Outside WRITE: rf_we=0 and done=0; outside LOAD/SCAN: alu_a=0, alu_b=0, rf_raddr=0.
REQ-028 start while busy, including in WRITE, SHALL be ignored with no queuing.
REQ-029 start held high continuously SHALL begin a new sweep in the IDLE cycle following each WRITE.
REQ-030 Comparison SHALL be unsigned and performed by the ALU; on ties either operand yields the same value.
REQ-031 dest within the swept range needs no hazard handling; the write occurs only after the sweep completes.
REQ-032 Exactly one rf_we pulse SHALL occur per accepted start, unless the sweep is aborted by rst.

Reset
REQ-033 rst=1 SHALL force state=IDLE and acc, idx, dest_q, result = 0, regardless of clk.
REQ-034 While rst=1, busy, done and rf_we SHALL be 0.
REQ-035 rst asserted mid-sweep SHALL abort with no register write and no done pulse.
REQ-036 The first start after rst deasserts SHALL be accepted normally.

Verification
REQ-037 Regs {9,4,7,12,3,15,8,6}, start with dest=5 -> done in cycle 9, single write addr 5 data 3, result=3, busy high for 9 cycles.
REQ-038 All regs 16'hFFFF -> write 16'hFFFF; then regs 16'h8000 except reg7=16'h0001 -> 16'h0001; then reg0=16'h0000, others 16'h8000 -> 16'h0000.
REQ-039 start pulsed in LOAD, in mid-SCAN and in WRITE -> exactly one done and one rf_we per accepted start; dest changes after acceptance have no effect.
REQ-040 rst asserted during the 4th SCAN cycle -> busy and done drop to 0 immediately, rf_we is never asserted, result=0; a fresh start then completes with the correct minimum.
REQ-041 start held high for 20 cycles -> sweeps run back-to-back with a 1-cycle IDLE gap and done in cycles 9 and 19.
